// File: rtl/i2c_adc_target_model.sv
// I2C target that behaves like an ADS1115-class ADC: a pointer-selected
// 4-entry register file and a timed conversion that latches sample_i.
module i2c_adc_target_model #(
  parameter logic [6:0]  ADDRESS     = 7'h48,
  parameter int unsigned CONV_CYCLES = 2000,
  parameter logic [15:0] CFG_RESET   = 16'h8583
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] sample_i,
  output logic        conv_busy_o,
  output logic        conv_done_o,
  output logic [15:0] config_o,
  output logic [1:0]  pointer_o,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ADDR       = 4'd1,
    S_ADDR_ACK   = 4'd2,
    S_PTR        = 4'd3,
    S_PTR_ACK    = 4'd4,
    S_WR_MSB     = 4'd5,
    S_WR_MSB_ACK = 4'd6,
    S_WR_LSB     = 4'd7,
    S_WR_LSB_ACK = 4'd8,
    S_RD_BYTE    = 4'd9,
    S_RD_ACK     = 4'd10,
    S_IGNORE     = 4'd11
  } state_t;

  localparam logic [15:0] CONV_LOAD = CONV_CYCLES[15:0];

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  msb_q;
  logic [15:0] shadow;
  logic        rw_q;
  logic        byte_sel;
  logic        mack_q;

  logic [15:0] conv_q;
  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic [15:0] conv_cnt;

  // Bus inputs are asynchronous: two flops, then one more for edge detection.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  logic [15:0] rd_mux;
  always_comb begin
    rd_mux = 16'h0000;
    case (pointer_o)
      2'b00:   rd_mux = conv_q;
      2'b01:   rd_mux = {~conv_busy_o, config_o[14:0]};
      2'b10:   rd_mux = lo_q;
      default: rd_mux = hi_q;
    endcase
  end

  logic [7:0] cur_byte, nxt_byte;
  assign cur_byte = byte_sel ? shadow[7:0]  : shadow[15:8];
  assign nxt_byte = byte_sel ? shadow[15:8] : shadow[7:0];

  // A register write commits only once the LSB byte has fully arrived.
  logic        wr_en;
  logic [15:0] wr_data;
  logic        os_start;
  assign wr_en    = (state == S_WR_LSB) && scl_fall && (bit_cnt == 4'd8);
  assign wr_data  = {msb_q, shreg};
  assign os_start = wr_en && (pointer_o == 2'b01) && wr_data[15];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      msb_q     <= 8'h00;
      shadow    <= 16'h0000;
      rw_q      <= 1'b0;
      byte_sel  <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe_o  <= 1'b0;
      pointer_o <= 2'b00;
    end else if (start_det) begin
      state    <= S_ADDR;
      bit_cnt  <= 4'd0;
      sda_oe_o <= 1'b0;
    end else if (stop_det) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      sda_oe_o <= 1'b0;
    end else begin
      if (scl_rise) begin
        case (state)
          S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB: begin
            shreg   <= {shreg[6:0], sda_s2};
            bit_cnt <= bit_cnt + 4'd1;
          end
          S_RD_BYTE: bit_cnt <= bit_cnt + 4'd1;
          S_RD_ACK:  mack_q  <= ~sda_s2;
          default: ;
        endcase
      end
      // SDA is only ever changed just after SCL falls, so it is stable while SCL is high.
      if (scl_fall) begin
        case (state)
          S_ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (shreg[7:1] == ADDRESS) begin
              state    <= S_ADDR_ACK;
              sda_oe_o <= 1'b1;
              rw_q     <= shreg[0];
              if (shreg[0]) shadow <= rd_mux;
            end else begin
              state <= S_IGNORE;
            end
          end
          S_ADDR_ACK: begin
            if (rw_q) begin
              state    <= S_RD_BYTE;
              byte_sel <= 1'b0;
              sda_oe_o <= ~shadow[15];
            end else begin
              state    <= S_PTR;
              sda_oe_o <= 1'b0;
            end
          end
          S_PTR: if (bit_cnt == 4'd8) begin
            pointer_o <= shreg[1:0];
            state     <= S_PTR_ACK;
            sda_oe_o  <= 1'b1;
            bit_cnt   <= 4'd0;
          end
          S_PTR_ACK: begin
            state    <= S_WR_MSB;
            sda_oe_o <= 1'b0;
          end
          S_WR_MSB: if (bit_cnt == 4'd8) begin
            msb_q    <= shreg;
            state    <= S_WR_MSB_ACK;
            sda_oe_o <= 1'b1;
            bit_cnt  <= 4'd0;
          end
          S_WR_MSB_ACK: begin
            state    <= S_WR_LSB;
            sda_oe_o <= 1'b0;
          end
          S_WR_LSB: if (bit_cnt == 4'd8) begin
            state    <= S_WR_LSB_ACK;
            sda_oe_o <= 1'b1;
            bit_cnt  <= 4'd0;
          end
          S_WR_LSB_ACK: begin
            state    <= S_WR_MSB;
            sda_oe_o <= 1'b0;
          end
          S_RD_BYTE: begin
            if (bit_cnt == 4'd8) begin
              state    <= S_RD_ACK;
              sda_oe_o <= 1'b0;
              bit_cnt  <= 4'd0;
            end else begin
              sda_oe_o <= ~cur_byte[3'd7 - bit_cnt[2:0]];
            end
          end
          S_RD_ACK: begin
            if (mack_q) begin
              state    <= S_RD_BYTE;
              byte_sel <= ~byte_sel;
              sda_oe_o <= ~nxt_byte[7];
            end else begin
              state    <= S_IGNORE;
              sda_oe_o <= 1'b0;
            end
          end
          default: sda_oe_o <= 1'b0;
        endcase
      end
    end
  end

  // A completing conversion and a new OS write in the same cycle both take effect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conv_q      <= 16'h0000;
      lo_q        <= 16'h8000;
      hi_q        <= 16'h7FFF;
      config_o    <= CFG_RESET;
      conv_busy_o <= 1'b0;
      conv_done_o <= 1'b0;
      conv_cnt    <= 16'h0000;
    end else begin
      conv_done_o <= 1'b0;
      if (conv_busy_o) begin
        if (conv_cnt == 16'd1) begin
          conv_q      <= sample_i;
          conv_done_o <= 1'b1;
          conv_busy_o <= 1'b0;
        end else begin
          conv_cnt <= conv_cnt - 16'd1;
        end
      end
      if (wr_en) begin
        case (pointer_o)
          2'b01:   config_o <= wr_data;
          2'b10:   lo_q     <= wr_data;
          2'b11:   hi_q     <= wr_data;
          default: ;
        endcase
      end
      if (os_start) begin
        conv_busy_o <= 1'b1;
        conv_cnt    <= CONV_LOAD;
      end
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_i2c_adc_target_model.sv
// Directed bench for the ADC target: an open-drain I2C master driver,
// a byte scoreboard for reads, and a table of register write/readback vectors.
module tb_i2c_adc_target_model;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] sample_i = 16'h1234;
  logic        sda_oe_o, conv_busy_o, conv_done_o;
  logic [15:0] config_o;
  logic [1:0]  pointer_o;
  logic [3:0]  dbg_state_o;
  logic        scl, sda;

  assign scl = m_scl;
  assign sda = m_sda & ~sda_oe_o;

  i2c_adc_target_model dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .scl_i       (scl),
    .sda_i       (sda),
    .sda_oe_o    (sda_oe_o),
    .sample_i    (sample_i),
    .conv_busy_o (conv_busy_o),
    .conv_done_o (conv_done_o),
    .config_o    (config_o),
    .pointer_o   (pointer_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, oe_cycles = 0, done_cnt = 0, done_cyc = 0, busy_rise_cyc = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sda_oe_o) oe_cycles <= oe_cycles + 1;
    if (conv_done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (conv_busy_o && !busy_prev) busy_rise_cyc <= cyc;
    busy_prev <= conv_busy_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks: SCL high and low phases are 10 clk each
  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    w(5);
    m_scl = 1'b1;
    w(5);
    s = sda;
    w(5);
    m_scl = 1'b0;
    w(5);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    w(5);
    m_scl = 1'b1;
    w(10);
    m_sda = 1'b0;
    w(10);
    m_scl = 1'b0;
    w(5);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    w(5);
    m_scl = 1'b1;
    w(10);
    m_sda = 1'b1;
    w(10);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack);
    logic s;
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~mack, s);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("rd_byte", {24'h0, d}, {24'h0, e});
  endtask

  task automatic wr_reg(input logic [1:0] ptr, input logic [15:0] d, output logic ok);
    logic a0, a1, a2, a3;
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte({6'b0, ptr}, a1);
    wr_byte(d[15:8], a2);
    wr_byte(d[7:0], a3);
    i2c_stop();
    ok = a0 & a1 & a2 & a3;
  endtask

  task automatic rd_reg(input logic [1:0] ptr, input int n, output logic ok);
    logic a0, a1, a2;
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte({6'b0, ptr}, a1);
    i2c_start();
    wr_byte(8'h91, a2);
    for (int k = 0; k < n; k++) rd_byte(k != n - 1);
    i2c_stop();
    ok = a0 & a1 & a2;
  endtask

  typedef struct packed {
    logic [1:0]  ptr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_cfg;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic ok, a0, a1, a2, a3;
    int   d0;
    logic seen;

    vecs[0] = '{2'd2, 16'hA5C3, 16'hA5C3, 16'hC383};
    vecs[1] = '{2'd3, 16'h5A3C, 16'h5A3C, 16'hC383};
    vecs[2] = '{2'd1, 16'h0583, 16'h8583, 16'h0583};
    vecs[3] = '{2'd1, 16'h7FFF, 16'hFFFF, 16'h7FFF};
    vecs[4] = '{2'd0, 16'hBEEF, 16'h1234, 16'h7FFF};

    // reset values
    rst_i = 1'b1;
    w(5);
    check("rst_sda_oe", {31'h0, sda_oe_o}, 32'h0);
    check("rst_busy", {31'h0, conv_busy_o}, 32'h0);
    check("rst_done", {31'h0, conv_done_o}, 32'h0);
    check("rst_pointer", {30'h0, pointer_o}, 32'h0);
    check("rst_config", {16'h0, config_o}, 32'h8583);
    check("rst_state", {28'h0, dbg_state_o}, 32'h0);
    rst_i = 1'b0;
    w(5);

    // config write with OS=1
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte(8'h01, a1);
    wr_byte(8'hC3, a2);
    wr_byte(8'h83, a3);
    i2c_stop();
    check("t1_ack_addr", {31'h0, a0}, 32'h1);
    check("t1_ack_ptr", {31'h0, a1}, 32'h1);
    check("t1_ack_msb", {31'h0, a2}, 32'h1);
    check("t1_ack_lsb", {31'h0, a3}, 32'h1);
    check("t1_config", {16'h0, config_o}, 32'hC383);
    check("t1_busy", {31'h0, conv_busy_o}, 32'h1);

    // config read while busy: OS bit reads 0
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h83);
    rd_reg(2'd1, 2, ok);
    check("t5_busy_rd_ack", {31'h0, ok}, 32'h1);

    seen = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check("t1_done_seen", {31'h0, seen}, 32'h1);
    check("t1_conv_latency", done_cyc - busy_rise_cyc, 32'd2000);
    w(5);
    check("t1_done_one_pulse", done_cnt - d0, 32'd1);
    check("t1_busy_clear", {31'h0, conv_busy_o}, 32'h0);

    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h83);
    rd_reg(2'd1, 2, ok);
    check("t5_idle_rd_ack", {31'h0, ok}, 32'h1);

    // conversion result readback
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    rd_reg(2'd0, 2, ok);
    check("t2_rd_ack", {31'h0, ok}, 32'h1);
    check("t2_pointer", {30'h0, pointer_o}, 32'h0);

    // foreign address is ignored
    d0 = oe_cycles;
    i2c_start();
    wr_byte(8'h94, a0);
    wr_byte(8'h01, a1);
    wr_byte(8'h00, a2);
    i2c_stop();
    check("t3_no_ack", {31'h0, a0}, 32'h0);
    check("t3_oe_quiet", oe_cycles - d0, 32'd0);
    check("t3_config", {16'h0, config_o}, 32'hC383);
    check("t3_pointer", {30'h0, pointer_o}, 32'h0);
    check("t3_state_idle", {28'h0, dbg_state_o}, 32'h0);

    // register write/readback table
    for (int i = 0; i < 5; i++) begin
      wr_reg(vecs[i].ptr, vecs[i].wdata, ok);
      check($sformatf("tbl%0d_wr_ack", i), {31'h0, ok}, 32'h1);
      check($sformatf("tbl%0d_config", i), {16'h0, config_o}, {16'h0, vecs[i].exp_cfg});
      exp_q.push_back(vecs[i].exp_rd[15:8]);
      exp_q.push_back(vecs[i].exp_rd[7:0]);
      rd_reg(vecs[i].ptr, 2, ok);
      check($sformatf("tbl%0d_rd_ack", i), {31'h0, ok}, 32'h1);
      check($sformatf("tbl%0d_pointer", i), {30'h0, pointer_o}, {30'h0, vecs[i].ptr});
    end

    // read wraps from LSB back to MSB of the same shadow
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h5A);
    rd_reg(2'd3, 3, ok);
    check("wrap_rd_ack", {31'h0, ok}, 32'h1);

    // two byte pairs in one frame rewrite the same register
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte(8'h02, a1);
    wr_byte(8'h11, a2);
    wr_byte(8'h11, a3);
    wr_byte(8'h22, a2);
    wr_byte(8'h22, a3);
    i2c_stop();
    check("pair_ack", {31'h0, a0 & a1 & a2 & a3}, 32'h1);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    rd_reg(2'd2, 2, ok);
    check("pair_rd_ack", {31'h0, ok}, 32'h1);

    // reset while driving a read bit low
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte(8'h00, a1);
    i2c_start();
    wr_byte(8'h91, a2);
    check("t6_ack", {31'h0, a0 & a1 & a2}, 32'h1);
    check("t6_driving_low", {31'h0, sda_oe_o}, 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("t6_oe_released", {31'h0, sda_oe_o}, 32'h0);
    w(3);
    rst_i = 1'b0;
    w(5);
    i2c_stop();
    check("t6_state_idle", {28'h0, dbg_state_o}, 32'h0);
    check("t6_pointer", {30'h0, pointer_o}, 32'h0);

    // MSB only then STOP discards the write
    i2c_start();
    wr_byte(8'h90, a0);
    wr_byte(8'h01, a1);
    wr_byte(8'h05, a2);
    i2c_stop();
    check("t4_ack", {31'h0, a0 & a1 & a2}, 32'h1);
    check("t4_config", {16'h0, config_o}, 32'h8583);
    exp_q.push_back(8'h85);
    exp_q.push_back(8'h83);
    rd_reg(2'd1, 2, ok);
    check("t4_cfg_rd_ack", {31'h0, ok}, 32'h1);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h00);
    rd_reg(2'd2, 2, ok);
    check("t6_lo_rd_ack", {31'h0, ok}, 32'h1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    rd_reg(2'd0, 2, ok);
    check("t6_conv_rd_ack", {31'h0, ok}, 32'h1);

    check("exp_q_drained", exp_q.size(), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
